// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM state encoding, legal parameter ranges
// and the parity function used by both the transmit and receive paths.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } tx_state_e;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 8;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;

  // Data is zero-extended to 8 bits by the caller; extra zeros do not alter the XOR.
  function automatic logic calc_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_framer.sv
// Tick-paced UART transmitter: start bit, LSB-first data, optional parity, stop bit(s).
// Define UART_TX_PARITY_EN to generate the parity bit and PARITY state.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
    $error("uart_tx_framer: DATA_BITS out of range");
  end
  if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
    $error("uart_tx_framer: STOP_BITS out of range");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("uart_tx_framer: PARITY_ODD must be 0 or 1");
  end

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  // Datapath registers carry no reset; they are always loaded on acceptance before use.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
`ifdef UART_TX_PARITY_EN
    par_q   <= par_d;
`endif
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d      = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (tx_valid) begin
          shreg_d    = tx_data;
          bit_cnt_d  = 3'd0;
          stop_cnt_d = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_d      = calc_parity(8'(tx_data), PARITY_ODD[0]);
`endif
          state_d    = ARM;
        end
      end
      ARM: begin
        if (baud_tick) begin
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (baud_tick) begin
          tx_d    = shreg_q[0];
          shreg_d = shreg_q >> 1;
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = par_q;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end else begin
            tx_d      = shreg_q[0];
            shreg_d   = shreg_q >> 1;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_tick) begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = STOP;
        end
      end
`endif
      STOP: begin
        if (baud_tick) begin
          if (stop_cnt_q == LAST_STOP) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  assign tx_ready = (state_q == IDLE);
  assign tx_busy  = (state_q != IDLE);
  assign tx       = tx_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: four instances (8N1 even, 8N1 odd, 8N2, 5N1)
// share one clock, reset and a 20-clock baud tick; frames are checked mid-bit.
module tb_uart_tx_framer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] tcnt = 5'd0;
  logic       baud_tick;
  logic [3:0] vld = 4'b0;
  logic [3:0] rdy, txl, busy, done;
  logic [7:0] din0 = 8'h00, din1 = 8'h00, din2 = 8'h00;
  logic [4:0] din3 = 5'h00;
  int         dcnt [4] = '{0, 0, 0, 0};
  int         n_total = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  // Baud tick source: one-cycle pulse every 20 clocks.
  always @(posedge clk) tcnt <= (tcnt == 5'd19) ? 5'd0 : tcnt + 5'd1;
  assign baud_tick = (tcnt == 5'd19);

  always @(posedge clk)
    for (int i = 0; i < 4; i++) if (done[i]) dcnt[i] <= dcnt[i] + 1;

  uart_tx_framer #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(din0), .tx_valid(vld[0]),
    .tx_ready(rdy[0]), .tx(txl[0]), .tx_busy(busy[0]), .tx_done(done[0]));
  uart_tx_framer #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(din1), .tx_valid(vld[1]),
    .tx_ready(rdy[1]), .tx(txl[1]), .tx_busy(busy[1]), .tx_done(done[1]));
  uart_tx_framer #(.DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(din2), .tx_valid(vld[2]),
    .tx_ready(rdy[2]), .tx(txl[2]), .tx_busy(busy[2]), .tx_done(done[2]));
  uart_tx_framer #(.DATA_BITS(5), .STOP_BITS(1), .PARITY_ODD(0)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(din3), .tx_valid(vld[3]),
    .tx_ready(rdy[3]), .tx(txl[3]), .tx_busy(busy[3]), .tx_done(done[3]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic drive(input int sel, input logic v, input logic [7:0] d);
    vld[sel] = v;
    case (sel)
      0: din0 = d;
      1: din1 = d;
      2: din2 = d;
      default: din3 = d[4:0];
    endcase
  endtask

  task automatic set_data(input int sel, input logic [7:0] d);
    drive(sel, vld[sel], d);
  endtask

  // Returns on the posedge at which baud_tick is sampled high.
  task automatic wait_tick();
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!baud_tick && n < 40);
    if (!baud_tick) chk("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic send(input int sel, input logic [7:0] d, input bit hold, input string tag);
    @(negedge clk);
    chk({tag, "_ready"}, 32'(rdy[sel]), 32'd1);
    drive(sel, 1'b1, d);
    @(posedge clk);
    @(negedge clk);
    if (!hold) drive(sel, 1'b0, d);
    chk({tag, "_busy"}, 32'(busy[sel]), 32'd1);
  endtask

  // Expects the frame for d starting at the next tick; checks every bit mid-period,
  // then the single tx_done pulse coinciding with the return to ready.
  task automatic check_frame(input int sel, input logic [7:0] d, input int nb, input int ns,
                             input logic odd, input string tag, input bit mid_chg,
                             input logic [7:0] mid_val);
    logic exp_bits[$];
    logic p;
    int   d_start;
    p = odd;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      exp_bits.push_back(d[i]);
      p ^= d[i];
    end
`ifdef UART_TX_PARITY_EN
    exp_bits.push_back(p);
`endif
    for (int i = 0; i < ns; i++) exp_bits.push_back(1'b1);
    d_start = dcnt[sel];
    wait_tick();
    foreach (exp_bits[k]) begin
      repeat (10) @(negedge clk);
      chk($sformatf("%s_bit%0d", tag, k), 32'(txl[sel]), 32'(exp_bits[k]));
      if (k != exp_bits.size() - 1)
        chk($sformatf("%s_nodone%0d", tag, k), 32'(dcnt[sel] - d_start), 32'd0);
      if (mid_chg && k == 3) set_data(sel, mid_val);
      wait_tick();
    end
    #1;
    chk({tag, "_done"}, 32'(done[sel]), 32'd1);
    chk({tag, "_ready_at_done"}, 32'(rdy[sel]), 32'd1);
    @(posedge clk);
    #1;
    chk({tag, "_done_off"}, 32'(done[sel]), 32'd0);
    chk({tag, "_done_count"}, 32'(dcnt[sel] - d_start), 32'd1);
  endtask

  initial begin
    int dc;
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_tx", 32'(txl), 32'hF);
    chk("rst_ready", 32'(rdy), 32'hF);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    send(0, 8'hA5, 1'b0, "a5_even");
    check_frame(0, 8'hA5, 8, 1, 1'b0, "a5_even", 1'b0, 8'h00);
    send(1, 8'hA5, 1'b0, "a5_odd");
    check_frame(1, 8'hA5, 8, 1, 1'b1, "a5_odd", 1'b0, 8'h00);

    // Two stop bits, valid held: second byte is taken in the tx_done cycle.
    send(2, 8'h00, 1'b1, "b2b0");
    check_frame(2, 8'h00, 8, 2, 1'b0, "b2b0", 1'b1, 8'hFF);
    chk("b2b1_accepted_at_done", 32'(busy[2]), 32'd1);
    drive(2, 1'b0, 8'hFF);
    check_frame(2, 8'hFF, 8, 2, 1'b0, "b2b1", 1'b0, 8'h00);

    // Abort during data bit 3 with an asynchronous reset pulse.
    send(0, 8'h5A, 1'b0, "abort");
    wait_tick();
    repeat (4) wait_tick();
    repeat (10) @(negedge clk);
    dc = dcnt[0];
    rst_n = 1'b0;
    #1;
    chk("abort_tx", 32'(txl[0]), 32'd1);
    chk("abort_ready", 32'(rdy[0]), 32'd1);
    chk("abort_busy", 32'(busy[0]), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) wait_tick();
    #1;
    chk("abort_no_done", 32'(dcnt[0] - dc), 32'd0);
    chk("abort_idle_tx", 32'(txl[0]), 32'd1);
    send(0, 8'h3C, 1'b0, "after_abort");
    check_frame(0, 8'h3C, 8, 1, 1'b0, "after_abort", 1'b0, 8'h00);

    send(3, 8'h13, 1'b0, "d5");
    check_frame(3, 8'h13, 5, 1, 1'b0, "d5", 1'b0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
